// File: rtl/shift_pipe_if.sv
// Request/result bus of the two-stage shift pipe.
//   in_*  : issue-side valid/ready request (data, count, op, tag)
//   out_* : writeback-side valid/ready result (data, tag, zero flag)
//   occ   : number of occupied pipe stages
// master drives requests and consumes results; slave is the shift unit.
interface shift_pipe_if #(
  parameter int unsigned TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_data;
  logic [3:0]       in_cnt;
  logic [1:0]       in_op;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_data;
  logic [TAG_W-1:0] out_tag;
  logic             out_zero;
  logic [1:0]       occ;

  modport master (
    output in_valid, in_data, in_cnt, in_op, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, out_zero, occ
  );

  modport slave (
    input  in_valid, in_data, in_cnt, in_op, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, out_zero, occ
  );
endinterface

// File: rtl/shift_pipe.sv
// Two-stage pipelined 16-bit shift unit.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   flush : synchronous kill of both stages (highest priority)
//   bus   : request/result handshake bus (slave side)
// Stage 1 registers operands; the barrel shifter feeds the stage-2 result
// register. One shift per cycle, 2-cycle latency, full backpressure.
module shift_pipe #(
  parameter int unsigned TAG_W = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  shift_pipe_if.slave bus
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    OP_ROL = 2'b00,
    OP_SLL = 2'b01,
    OP_ROR = 2'b10,
    OP_SRL = 2'b11
  } op_e;

  logic              s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0] s1_data_q,  s1_data_d;
  logic [CNT_W-1:0]  s1_cnt_q,   s1_cnt_d;
  op_e               s1_op_q,    s1_op_d;
  logic [TAG_W-1:0]  s1_tag_q,   s1_tag_d;

  logic              s2_valid_q, s2_valid_d;
  logic [DATA_W-1:0] s2_data_q,  s2_data_d;
  logic [TAG_W-1:0]  s2_tag_q,   s2_tag_d;
  logic              s2_zero_q,  s2_zero_d;

  logic              s2_take, s1_move, in_fire, out_fire;
  logic [2*DATA_W-1:0] dbl, rol_w, ror_w;
  logic [DATA_W-1:0] shift_res;

  // Handshake / stage-advance terms
  assign s2_take  = !s2_valid_q || bus.out_ready;
  assign s1_move  = s1_valid_q && s2_take;
  assign in_fire  = bus.in_valid && bus.in_ready;
  assign out_fire = s2_valid_q && bus.out_ready;

  assign bus.in_ready  = !s1_valid_q || s2_take;
  assign bus.out_valid = s2_valid_q;
  assign bus.out_data  = s2_data_q;
  assign bus.out_tag   = s2_tag_q;
  assign bus.out_zero  = s2_zero_q;
  assign bus.occ       = {1'b0, s1_valid_q} + {1'b0, s2_valid_q};

  // Barrel shifter: rotates taken from a doubled word so count 0 passes through
  always_comb begin
    dbl   = {s1_data_q, s1_data_q};
    rol_w = dbl << s1_cnt_q;
    ror_w = dbl >> s1_cnt_q;
    case (s1_op_q)
      OP_ROL:  shift_res = rol_w[2*DATA_W-1:DATA_W];
      OP_SLL:  shift_res = s1_data_q << s1_cnt_q;
      OP_ROR:  shift_res = ror_w[DATA_W-1:0];
      default: shift_res = s1_data_q >> s1_cnt_q;
    endcase
  end

  // Next-state for both stages; flush overrides the valid bits only
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_cnt_d   = s1_cnt_q;
    s1_op_d    = s1_op_q;
    s1_tag_d   = s1_tag_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_tag_d   = s2_tag_q;
    s2_zero_d  = s2_zero_q;

    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_data_d  = bus.in_data;
      s1_cnt_d   = bus.in_cnt;
      s1_op_d    = op_e'(bus.in_op);
      s1_tag_d   = bus.in_tag;
    end else if (s1_move) begin
      s1_valid_d = 1'b0;
    end

    if (s1_move) begin
      s2_valid_d = 1'b1;
      s2_data_d  = shift_res;
      s2_tag_d   = s1_tag_q;
      s2_zero_d  = (shift_res == '0);
    end else if (out_fire) begin
      s2_valid_d = 1'b0;
    end

    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end
  end

  // Pipeline registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_cnt_q   <= '0;
      s1_op_q    <= OP_ROL;
      s1_tag_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_tag_q   <= '0;
      s2_zero_q  <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_cnt_q   <= s1_cnt_d;
      s1_op_q    <= s1_op_d;
      s1_tag_q   <= s1_tag_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_tag_q   <= s2_tag_d;
      s2_zero_q  <= s2_zero_d;
    end
  end

endmodule

// File: tb/tb_shift_pipe.sv
// Self-checking bench for shift_pipe: accepted requests are pushed to a
// scoreboard with a bit-serial reference result; results are popped in order.
module tb_shift_pipe;

  localparam int unsigned TAG_W = 4;

  typedef struct packed {
    logic [15:0]      data;
    logic [TAG_W-1:0] tag;
    logic             zero;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  int   tests_run = 0;
  int   tests_failed = 0;
  exp_t sb_q[$];

  shift_pipe_if #(.TAG_W(TAG_W)) bus ();

  shift_pipe #(.TAG_W(TAG_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference: apply the op one bit position at a time
  function automatic logic [15:0] ref_shift(input logic [15:0] d, input logic [3:0] c,
                                            input logic [1:0] op);
    logic [15:0] r;
    r = d;
    for (int i = 0; i < int'(c); i++) begin
      case (op)
        2'b00:   r = {r[14:0], r[15]};
        2'b01:   r = {r[14:0], 1'b0};
        2'b10:   r = {r[0], r[15:1]};
        default: r = {1'b0, r[15:1]};
      endcase
    end
    return r;
  endfunction

  // Scoreboard push on accept, pop/compare on result consumption
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.in_valid && bus.in_ready && !flush) begin
        exp_t e;
        e.data = ref_shift(bus.in_data, bus.in_cnt, bus.in_op);
        e.tag  = bus.in_tag;
        e.zero = (e.data == 16'h0);
        sb_q.push_back(e);
      end
      if (bus.out_valid && bus.out_ready) begin
        tests_run++;
        if (sb_q.size() == 0) begin
          tests_failed++;
          $display("FAIL sb_unexpected: got data=%h tag=%h, required no result", bus.out_data, bus.out_tag);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          if ({bus.out_data, bus.out_tag, bus.out_zero} !== e) begin
            tests_failed++;
            $display("FAIL sb_result: got data=%h tag=%h zero=%b, required data=%h tag=%h zero=%b",
                     bus.out_data, bus.out_tag, bus.out_zero, e.data, e.tag, e.zero);
          end
        end
      end
    end
  end

  task automatic set_req(input logic [15:0] d, input logic [3:0] c, input logic [1:0] op,
                         input logic [TAG_W-1:0] t);
    bus.in_data = d;
    bus.in_cnt  = c;
    bus.in_op   = op;
    bus.in_tag  = t;
  endtask

  // Offer one request until accepted; returns 1ns after the accepting edge
  task automatic send(input logic [15:0] d, input logic [3:0] c, input logic [1:0] op,
                      input logic [TAG_W-1:0] t);
    bit ok = 1'b0;
    set_req(d, c, op, t);
    bus.in_valid = 1'b1;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL send_timeout: got in_ready=0 for 40 cycles, required acceptance");
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb_q.size() != 0 || bus.out_valid) && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    tests_run++;
    if (n >= 40) begin
      tests_failed++;
      $display("FAIL drain_timeout: got %0d pending, required 0", sb_q.size());
    end
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; flush = 1'b0;
    set_req(16'h0, 4'h0, 2'b00, '0);
    rst_n = 1'b0;
    #12;
    tests_run++;
    if ({bus.out_valid, bus.out_data, bus.out_tag, bus.out_zero, bus.occ} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got valid=%b data=%h tag=%h zero=%b occ=%0d, required all 0",
               bus.out_valid, bus.out_data, bus.out_tag, bus.out_zero, bus.occ);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests_run++;
    if (bus.in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_in_ready: got %b, required 1", bus.in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    bus.out_ready = 1'b1;
    send(16'h8001, 4'd1, 2'b00, 4'd3);
    tests_run++;
    if (bus.out_valid !== 1'b0 || bus.occ !== 2'd1) begin
      tests_failed++;
      $display("FAIL single_stage1: got out_valid=%b occ=%0d, required 0/1", bus.out_valid, bus.occ);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h0003 || bus.out_tag !== 4'd3 || bus.out_zero !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_result: got valid=%b data=%h tag=%h zero=%b, required 1/0003/3/0",
               bus.out_valid, bus.out_data, bus.out_tag, bus.out_zero);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (bus.occ !== 2'd0 || bus.out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_empty: got occ=%0d valid=%b, required 0/0", bus.occ, bus.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] d_a [4] = '{16'h00FF, 16'h0001, 16'h8000, 16'h1234};
    logic [3:0]  c_a [4] = '{4'd4, 4'd1, 4'd15, 4'd0};
    logic [1:0]  o_a [4] = '{2'b01, 2'b10, 2'b11, 2'b01};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_req(d_a[i], c_a[i], o_a[i], TAG_W'(i + 8));
      bus.in_valid = 1'b1;
      @(negedge clk);
      tests_run++;
      if (bus.in_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL b2b_in_ready[%0d]: got %b, required 1", i, bus.in_ready);
      end
      if (i >= 2) begin
        tests_run++;
        if (bus.out_valid !== 1'b1) begin
          tests_failed++;
          $display("FAIL b2b_out_valid[%0d]: got %b, required 1", i - 2, bus.out_valid);
        end
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    for (int i = 2; i < 5; i++) begin
      @(negedge clk);
      tests_run++;
      if (bus.out_valid !== (i < 4)) begin
        tests_failed++;
        $display("FAIL b2b_out_valid[%0d]: got %b, required %b", i, bus.out_valid, (i < 4));
      end
      @(posedge clk);
      #1;
    end
    wait_drain();
  endtask

  task automatic test_backpressure();
    logic [15:0] held;
    bus.out_ready = 1'b0;
    send(16'h1111, 4'd1, 2'b00, 4'd1);
    send(16'h00F0, 4'd3, 2'b01, 4'd2);
    set_req(16'hF000, 4'd4, 2'b11, 4'd4);
    bus.in_valid = 1'b1;
    @(negedge clk);
    tests_run++;
    if (bus.in_ready !== 1'b0 || bus.occ !== 2'd2 || bus.out_data !== 16'h2222) begin
      tests_failed++;
      $display("FAIL bp_full: got in_ready=%b occ=%0d data=%h, required 0/2/2222",
               bus.in_ready, bus.occ, bus.out_data);
    end
    held = bus.out_data;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++;
      if (bus.out_data !== held || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
        tests_failed++;
        $display("FAIL bp_stall[%0d]: got data=%h in_ready=%b valid=%b, required %h/0/1",
                 i, bus.out_data, bus.in_ready, bus.out_valid, held);
      end
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    #1;
    tests_run++;
    if (bus.in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_release: got in_ready=%b, required 1", bus.in_ready);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    wait_drain();
  endtask

  task automatic test_zero();
    bus.out_ready = 1'b1;
    send(16'h00F0, 4'd12, 2'b01, 4'd5);
    @(posedge clk);
    #1;
    tests_run++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h0000 || bus.out_zero !== 1'b1) begin
      tests_failed++;
      $display("FAIL zero_set: got valid=%b data=%h zero=%b, required 1/0000/1",
               bus.out_valid, bus.out_data, bus.out_zero);
    end
    send(16'h00F0, 4'd4, 2'b11, 4'd6);
    @(posedge clk);
    #1;
    tests_run++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h000F || bus.out_zero !== 1'b0) begin
      tests_failed++;
      $display("FAIL zero_clear: got valid=%b data=%h zero=%b, required 1/000F/0",
               bus.out_valid, bus.out_data, bus.out_zero);
    end
    wait_drain();
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    send(16'hAAAA, 4'd1, 2'b01, 4'd7);
    send(16'h5555, 4'd2, 2'b00, 4'd9);
    set_req(16'hBEEF, 4'd3, 2'b10, 4'd10);
    bus.in_valid = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    tests_run++;
    if (bus.occ !== 2'd2) begin
      tests_failed++;
      $display("FAIL flush_pre_occ: got %0d, required 2", bus.occ);
    end
    @(posedge clk);
    #1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    sb_q.delete();
    tests_run++;
    if (bus.occ !== 2'd0 || bus.out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_empty: got occ=%0d valid=%b, required 0/0", bus.occ, bus.out_valid);
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests_run++;
      if (bus.out_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL flush_stale[%0d]: got out_valid=%b data=%h, required 0", i, bus.out_valid, bus.out_data);
      end
    end
    @(posedge clk);
    #1;
    send(16'h0F00, 4'd4, 2'b10, 4'd11);
    @(posedge clk);
    #1;
    tests_run++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h00F0 || bus.out_tag !== 4'd11) begin
      tests_failed++;
      $display("FAIL flush_after: got valid=%b data=%h tag=%h, required 1/00F0/b",
               bus.out_valid, bus.out_data, bus.out_tag);
    end
    wait_drain();
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    send(16'h1234, 4'd4, 2'b00, 4'd12);
    send(16'h4321, 4'd8, 2'b10, 4'd13);
    #3;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 16'h0 || bus.occ !== 2'd0) begin
      tests_failed++;
      $display("FAIL rst_mid: got valid=%b data=%h occ=%0d, required 0/0000/0",
               bus.out_valid, bus.out_data, bus.occ);
    end
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests_run++;
    if (bus.in_ready !== 1'b1 || bus.occ !== 2'd0) begin
      tests_failed++;
      $display("FAIL rst_mid_release: got in_ready=%b occ=%0d, required 1/0", bus.in_ready, bus.occ);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    send(16'h00C3, 4'd2, 2'b01, 4'd14);
    @(posedge clk);
    #1;
    tests_run++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h030C) begin
      tests_failed++;
      $display("FAIL rst_mid_after: got valid=%b data=%h, required 1/030C", bus.out_valid, bus.out_data);
    end
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_zero();
    test_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/shift_pipe.md
Name: shift_pipe

Overview:
Two-stage pipelined shift unit for the execute-stage ALU path. It accepts shift requests from the decode/issue side over a valid/ready handshake. Stage 1 registers the request operands. The existing combinational shift16 barrel shifter sits between stage 1 and the stage-2 result register. Stage 2 presents the result to writeback over a second valid/ready handshake. Sustains one shift per cycle with 2-cycle latency, with backpressure and flush for branch mispredict.

Parameters:
TAG_W, 4, width of the opaque tag carried alongside each request (destination register id).

Ports:
clk  input  1  clock; all flops rising-edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous kill of all in-flight requests
in_valid  input  1  request present
in_ready  output  1  unit can accept the request this cycle
in_data  input  16  value to shift
in_cnt  input  4  shift amount 0..15
in_op  input  2  shift op: 00 rotate left, 01 shift left logical, 10 rotate right, 11 shift right logical
in_tag  input  TAG_W  opaque tag
out_valid  output  1  result present
out_ready  input  1  consumer accepts the result this cycle
out_data  output  16  shifted result (registered)
out_tag  output  TAG_W  tag of the result
out_zero  output  1  out_data == 0 (registered alongside out_data)
occ  output  2  number of valid stages (0..2)

Behaviour:
- Reset (rst_n low, async): s1_valid=0, s2_valid=0; all data/tag/op/cnt registers = 0. out_valid=0, out_data=0, out_tag=0, out_zero=0, occ=0. in_ready=1 once reset deasserts (combinational, see below).
- Handshakes: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready. out_valid = s2_valid.
- Stage advance rules, with flush low:
  - s2_take = !s2_valid | out_ready.
  - s1_move = s1_valid & s2_take.
  - in_ready = !s1_valid | s2_take. Combinational path from out_ready is permitted.
  - Data is never dropped or duplicated. out_data, out_tag and out_zero are held stable while out_valid=1 and out_ready=0.
- Stage 1 update:
  - On in_fire, capture in_data, in_cnt, in_op and in_tag; s1_valid <= 1.
  - Else, if s1_move, s1_valid <= 0.
  - Simultaneous in_fire and s1_move: the new request replaces the old one; s1_valid stays 1.
- Stage 2 update:
  - On s1_move, out_data <= shift(s1 operands), out_tag <= s1 tag, out_zero <= (shift result == 0); s2_valid <= 1.
  - Else, if out_fire, s2_valid <= 0.
- Shift arithmetic:
  - Modulo 16 on the count; in_cnt=0 gives a pass-through.
  - Logical shifts fill with zeros. Rotates wrap bit 15 to bit 0 (left) or bit 0 to bit 15 (right).
- Latency and throughput:
  - A request accepted on edge N appears with out_valid=1 after edge N+1, i.e. 2 cycles, when unstalled.
  - Full throughput is 1 request per cycle when out_ready is held at 1.
- Backpressure: with out_ready=0, the pipe fills at most 2 deep. in_ready deasserts in the cycle s1 and s2 are both valid. With occ=2 and out_ready rising, in_ready rises in the same cycle.
- Flush (highest priority, synchronous):
  - Next edge: s1_valid <= 0, s2_valid <= 0. Data registers may retain values.
  - A request presented with in_valid during the flush cycle is discarded, even if in_ready=1.
  - An out_fire in the flush cycle still counts as consumed by the consumer.
- occ = s1_valid + s2_valid.
- Reset mid-operation: all in-flight requests are lost immediately; outputs go to reset values asynchronously.

Test Plan:
- Single request in_data=0x8001, cnt=1, op=00, tag=3, with out_ready=1 -> out_valid exactly 2 cycles after acceptance with out_data=0x0003, out_tag=3, out_zero=0, occ back to 0.
- Back-to-back stream, out_ready=1, four requests, one per cycle:
  - (0x00FF,4,01) -> 0x0FF0
  - (0x0001,1,10) -> 0x8000
  - (0x8000,15,11) -> 0x0001
  - (0x1234,0,01) -> 0x1234
  - in_ready stays 1 throughout; results arrive in order on 4 consecutive cycles.
- Backpressure: out_ready=0, three requests offered -> two accepted, occ=2, in_ready=0. The third is accepted the cycle out_ready goes 1. All three come out in order and out_data stays stable while stalled.
- Zero flag: (0x00F0,12,01) -> out_data=0x0000, out_zero=1. Then (0x00F0,4,11) -> 0x000F, out_zero=0.
- Flush: occ=2 plus in_valid=1 during the flush cycle -> next cycle occ=0, out_valid=0, and no stale or flushed result appears afterward. The next post-flush request completes normally with 2-cycle latency.
- Async reset asserted mid-stream, between clock edges -> out_valid, out_data and occ go to 0 immediately. After rst_n rises, in_ready=1 and the pipe operates normally.
